int_req_arb: RTL and testbench
==============================

Name: int_req_arb

Overview:
- Interrupt request arbiter in front of the interrupt/exception handler.
- Collects up to N_SRC external interrupt lines, edge-detects and latches them as pending, applies a software mask and selects one winner by fixed priority (lowest index wins).
- Drives the single int request plus a vector number and IDT entry address into the handler; holds the request until the handler acknowledges with int_clear.
- Tracks the in-service source until IRET completes; no nesting.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- VEC_BASE, 8'h20, vector number of source 0; source i uses VEC_BASE+i.
- IDT_BASE, 32'h0000_2000, IDT base byte address; entries are 8 bytes.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  N_SRC  interrupt lines, synchronous to clk, rising-edge triggered.
- mask_wr  in  1  one-cycle strobe, loads mask_data into the mask register.
- mask_data  in  N_SRC  new mask; 1 = source masked.
- int_clear  in  1  one-cycle pulse from the handler, request accepted.
- iret_done  in  1  one-cycle pulse, IRET of the current handler retired.
- int  out  1  interrupt request to the handler.
- int_vec  out  8  vector number of the selected source.
- int_idt_addr  out  32  IDT_BASE + 8*int_vec (low 32 bits, wrap ignored).
- pending  out  N_SRC  latched pending bits.
- in_service  out  N_SRC  one-hot in-service source, or 0.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - irq_q=0, pending=0, mask=0 (all enabled), in_service=0, state=IDLE.
  - int=0, busy=0, sel=0, so int_vec=VEC_BASE and int_idt_addr=IDT_BASE+8*VEC_BASE.
  - Reset asserted mid-operation aborts any request or service immediately with no completion.
- Edge detect:
  - irq_q<=irq every cycle; rise=irq&~irq_q.
  - A line already high when reset is released produces a rise on the first clock.
- Pending:
  - pending[i]<=1 on rise[i].
  - Cleared only by int_clear for the selected source.
  - If rise[i] and clear[i] occur in the same cycle, the set wins (pending stays 1).
  - Level-high lines without a new edge do not re-pend.
- Mask:
  - On mask_wr, mask<=mask_data; takes effect for arbitration the next cycle.
  - Masked sources still latch pending.
  - Unmasking a pending source makes it eligible.
- eligible=pending&~mask. Winner is the lowest set index.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible!=0, latch sel=winner index and go to REQ. Otherwise stay.
  - REQ: int=1. int_vec and int_idt_addr are held from sel; later higher-priority edges and mask writes do not change sel. On int_clear: clear pending[sel], set in_service=onehot(sel), go to SERVICE. iret_done is ignored.
  - SERVICE: int=0, sel held. On iret_done: in_service<=0, go to IDLE. int_clear is ignored. If int_clear and iret_done arrive together, only iret_done is honoured.
- Outputs int, busy and in_service are registered (decoded from state and registers, no input-to-output paths).
- Latency:
  - irq sampled high at edge E0 gives pending=1 after E0 and int=1 after E1.
  - int_clear sampled at edge Ek gives int=0 after Ek.
  - After iret_done, the next eligible source raises int two edges later: IDLE for one cycle, then REQ.
  - Back-to-back requests never overlap.
- int_vec = VEC_BASE+sel (8-bit, mod 256). int_idt_addr = IDT_BASE + {int_vec,3'b000}.

Test Plan:
- Reset, then irq=4'b0100 held: pending=0100 after E0; int=1 after E1 with int_vec=8'h22, int_idt_addr=32'h0000_2110; pulse int_clear gives int=0, pending=0, in_service=0100; pulse iret_done gives in_service=0, busy=0.
- irq[3] and irq[1] rise in the same cycle: sel=1 (vector 8'h21); after int_clear and iret_done, source 3 is requested with vector 8'h23, int_idt_addr=32'h0000_2118.
- mask_data=4'b0001 written, then irq[0] rises: pending=0001, int stays 0; write mask 0, and int=1 one cycle after the write is seen, vector 8'h20.
- In REQ for source 2, irq[0] rises and mask bit 2 is set: int_vec stays 8'h22 until int_clear; source 0 is served next.
- In REQ for source 1, irq[1] pulses low then high so its rise coincides with int_clear: pending[1] stays 1, and source 1 is re-requested after iret_done.
- rst_n pulsed low while in SERVICE with pending=1010: all outputs return to reset values immediately; int_clear and iret_done alone raise no request after reset is released.

Source files
------------

// File: rtl/int_req_arb.sv
// Interrupt request arbiter: edge-latched pending, software mask, fixed priority (lowest index wins).
// Latency: irq edge -> pending 1 cycle, -> int_req 2 cycles; next request 2 cycles after iret_done.
// Backpressure: request held until int_clear; further requests wait until iret_done (no nesting).
module int_req_arb #(
    parameter int          N_SRC    = 4,
    parameter logic [7:0]  VEC_BASE = 8'h20,
    parameter logic [31:0] IDT_BASE = 32'h0000_2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  irq,
    input  logic              mask_wr,
    input  logic [N_SRC-1:0]  mask_data,
    input  logic              int_clear,
    input  logic              iret_done,
    output logic              int_req,
    output logic [7:0]        int_vec,
    output logic [31:0]       int_idt_addr,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  in_service,
    output logic              busy
);

    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] mask;
    logic [SEL_W-1:0] sel;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] sel_oh;
    logic [N_SRC-1:0] clr;
    logic [SEL_W-1:0] win_idx;

    assign rise     = irq & ~irq_q;
    assign eligible = pending & ~mask;

    // Scanning high-to-low lets the lowest eligible index overwrite last.
    always_comb begin
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = SEL_W'(i);
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sel_oh[i] = (sel == SEL_W'(i));
        end
    end

    assign clr = (state == REQ && int_clear) ? sel_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            in_service <= '0;
            sel        <= '0;
            state      <= IDLE;
        end else begin
            irq_q   <= irq;
            // A fresh edge in the same cycle as the clear keeps the source pending.
            pending <= (pending & ~clr) | rise;
            if (mask_wr) mask <= mask_data;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        sel   <= win_idx;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (int_clear) begin
                        in_service <= sel_oh;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (iret_done) begin
                        in_service <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign int_req      = (state == REQ);
    assign busy         = (state != IDLE);
    assign int_vec      = VEC_BASE + {{(8 - SEL_W){1'b0}}, sel};
    assign int_idt_addr = IDT_BASE + {21'd0, int_vec, 3'b000};

endmodule

// File: tb/tb_int_req_arb.sv
// Directed bench for int_req_arb: fixed-priority arbitration, masking, clear/set races and reset abort.
module tb_int_req_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq;
    logic        mask_wr;
    logic [3:0]  mask_data;
    logic        int_clear;
    logic        iret_done;
    logic        int_req;
    logic [7:0]  int_vec;
    logic [31:0] int_idt_addr;
    logic [3:0]  pending;
    logic [3:0]  in_service;
    logic        busy;

    int n_chk;
    int n_fail;

    int_req_arb #(
        .N_SRC   (4),
        .VEC_BASE(8'h20),
        .IDT_BASE(32'h0000_2000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq         (irq),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .int_clear   (int_clear),
        .iret_done   (iret_done),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_idt_addr(int_idt_addr),
        .pending     (pending),
        .in_service  (in_service),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
    endtask

    task automatic pulse_iret();
        iret_done = 1'b1;
        tick();
        iret_done = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        irq       = 4'b0000;
        mask_wr   = 1'b0;
        mask_data = 4'b0000;
        int_clear = 1'b0;
        iret_done = 1'b0;
        #2;
        chk("rst_int",  {31'd0, int_req}, 32'd0);
        chk("rst_busy", {31'd0, busy},    32'd0);
        chk("rst_vec",  {24'd0, int_vec}, 32'h20);
        chk("rst_idt",  int_idt_addr,     32'h0000_2100);
        chk("rst_pend", {28'd0, pending}, 32'd0);
        chk("rst_insv", {28'd0, in_service}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single source 2, held high
        irq = 4'b0100;
        tick();
        chk("t1_pend_e0", {28'd0, pending}, 32'h4);
        chk("t1_int_e0",  {31'd0, int_req}, 32'd0);
        tick();
        chk("t1_int_e1",  {31'd0, int_req}, 32'd1);
        chk("t1_vec",     {24'd0, int_vec}, 32'h22);
        chk("t1_idt",     int_idt_addr,     32'h0000_2110);
        pulse_clear();
        chk("t1_int_clr",  {31'd0, int_req},    32'd0);
        chk("t1_pend_clr", {28'd0, pending},    32'd0);
        chk("t1_insv",     {28'd0, in_service}, 32'h4);
        chk("t1_busy_svc", {31'd0, busy},       32'd1);
        pulse_iret();
        chk("t1_insv_done", {28'd0, in_service}, 32'd0);
        chk("t1_busy_done", {31'd0, busy},       32'd0);
        tick();
        chk("t1_no_repend", {28'd0, pending}, 32'd0);
        chk("t1_no_req",    {31'd0, int_req}, 32'd0);

        // Sources 3 and 1 rise together
        irq = 4'b1110;
        tick();
        chk("t2_pend", {28'd0, pending}, 32'hA);
        tick();
        chk("t2_int1", {31'd0, int_req}, 32'd1);
        chk("t2_vec1", {24'd0, int_vec}, 32'h21);
        pulse_clear();
        chk("t2_pend_after", {28'd0, pending},    32'h8);
        chk("t2_insv",       {28'd0, in_service}, 32'h2);
        tick();
        chk("t2_svc_int", {31'd0, int_req}, 32'd0);
        pulse_iret();
        chk("t2_idle_gap", {31'd0, int_req}, 32'd0);
        tick();
        chk("t2_int3", {31'd0, int_req}, 32'd1);
        chk("t2_vec3", {24'd0, int_vec}, 32'h23);
        chk("t2_idt3", int_idt_addr,     32'h0000_2118);
        pulse_clear();
        pulse_iret();
        irq = 4'b0000;
        tick();

        // Masked source 0
        mask_wr   = 1'b1;
        mask_data = 4'b0001;
        tick();
        mask_wr = 1'b0;
        irq = 4'b0001;
        tick();
        chk("t3_pend", {28'd0, pending}, 32'h1);
        tick();
        chk("t3_masked_int", {31'd0, int_req}, 32'd0);
        mask_wr   = 1'b1;
        mask_data = 4'b0000;
        tick();
        mask_wr = 1'b0;
        chk("t3_int_wr_edge", {31'd0, int_req}, 32'd0);
        tick();
        chk("t3_int_unmask", {31'd0, int_req}, 32'd1);
        chk("t3_vec",        {24'd0, int_vec}, 32'h20);
        pulse_clear();
        pulse_iret();
        irq = 4'b0000;
        tick();

        // Request for source 2 is not disturbed by a higher edge or a mask write
        irq = 4'b0100;
        tick();
        tick();
        chk("t4_vec_req", {24'd0, int_vec}, 32'h22);
        irq       = 4'b0101;
        mask_wr   = 1'b1;
        mask_data = 4'b0100;
        tick();
        mask_wr = 1'b0;
        chk("t4_vec_hold", {24'd0, int_vec}, 32'h22);
        chk("t4_pend",     {28'd0, pending}, 32'h5);
        tick();
        chk("t4_int_hold", {31'd0, int_req}, 32'd1);
        chk("t4_vec_hold2", {24'd0, int_vec}, 32'h22);
        pulse_clear();
        chk("t4_pend_clr", {28'd0, pending},    32'h1);
        chk("t4_insv",     {28'd0, in_service}, 32'h4);
        pulse_iret();
        tick();
        chk("t4_next_int", {31'd0, int_req}, 32'd1);
        chk("t4_next_vec", {24'd0, int_vec}, 32'h20);
        mask_wr   = 1'b1;
        mask_data = 4'b0000;
        tick();
        mask_wr = 1'b0;
        pulse_clear();
        pulse_iret();
        irq = 4'b0000;
        tick();

        // Rising edge on source 1 coincides with its clear
        irq = 4'b0010;
        tick();
        tick();
        chk("t5_vec", {24'd0, int_vec}, 32'h21);
        irq = 4'b0000;
        tick();
        irq       = 4'b0010;
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
        chk("t5_pend_kept", {28'd0, pending},    32'h2);
        chk("t5_insv",      {28'd0, in_service}, 32'h2);
        chk("t5_svc_int",   {31'd0, int_req},    32'd0);
        pulse_iret();
        tick();
        chk("t5_rereq",     {31'd0, int_req}, 32'd1);
        chk("t5_rereq_vec", {24'd0, int_vec}, 32'h21);
        pulse_clear();
        chk("t5_pend_final", {28'd0, pending}, 32'd0);
        pulse_iret();
        irq = 4'b0000;
        tick();

        // Reset while in SERVICE with pending 1010
        irq = 4'b1010;
        tick();
        tick();
        chk("t6_vec", {24'd0, int_vec}, 32'h21);
        irq = 4'b1000;
        tick();
        irq       = 4'b1010;
        int_clear = 1'b1;
        tick();
        int_clear = 1'b0;
        chk("t6_pend", {28'd0, pending},    32'hA);
        chk("t6_insv", {28'd0, in_service}, 32'h2);
        chk("t6_busy", {31'd0, busy},       32'd1);
        #2;
        rst_n = 1'b0;
        irq   = 4'b0000;
        #1;
        chk("t6_rst_int",  {31'd0, int_req},    32'd0);
        chk("t6_rst_busy", {31'd0, busy},       32'd0);
        chk("t6_rst_pend", {28'd0, pending},    32'd0);
        chk("t6_rst_insv", {28'd0, in_service}, 32'd0);
        chk("t6_rst_vec",  {24'd0, int_vec},    32'h20);
        chk("t6_rst_idt",  int_idt_addr,        32'h0000_2100);
        tick();
        rst_n = 1'b1;
        pulse_clear();
        pulse_iret();
        tick();
        tick();
        chk("t6_post_int",  {31'd0, int_req}, 32'd0);
        chk("t6_post_busy", {31'd0, busy},    32'd0);
        chk("t6_post_pend", {28'd0, pending}, 32'd0);

        // Line already high at reset release rises on the first clock
        rst_n = 1'b0;
        irq   = 4'b0001;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_pend", {28'd0, pending}, 32'h1);
        tick();
        chk("t7_int", {31'd0, int_req}, 32'd1);
        chk("t7_vec", {24'd0, int_vec}, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
